// File: rtl/window_3x3_gen_if.sv
// Pixel-stream and 3x3-window bundle for window_3x3_gen.
// The source side (master) drives pixels and receives windows; the generator is the slave.
interface window_3x3_gen_if #(
    parameter int DW = 8,
    parameter int CW = 11
);
    logic [DW-1:0] pix_in;
    logic          pix_valid;
    logic          sof;

    logic [DW-1:0] c1, c2, c3, c4, c5, c6, c7, c8, c9;
    logic          win_valid;
    logic [CW-1:0] win_x;
    logic [CW-1:0] win_y;
    logic          frame_done;

    modport master (
        output pix_in, pix_valid, sof,
        input  c1, c2, c3, c4, c5, c6, c7, c8, c9,
        input  win_valid, win_x, win_y, frame_done
    );

    modport slave (
        input  pix_in, pix_valid, sof,
        output c1, c2, c3, c4, c5, c6, c7, c8, c9,
        output win_valid, win_x, win_y, frame_done
    );
endinterface

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus per-row column history
// turn a raster pixel stream into one registered 3x3 window per interior pixel.
module window_3x3_gen #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int DW    = 8,
    parameter int CW    = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    window_3x3_gen_if.slave bus
);
    localparam int            AW     = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam logic [CW-1:0] LAST_X = CW'(IMG_W - 1);
    localparam logic [CW-1:0] LAST_Y = CW'(IMG_H - 1);
    localparam logic [CW-1:0] TWO    = CW'(2);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        state_q;
    logic [CW-1:0] col_q, row_q;
    logic [CW-1:0] col_d, row_d;

    logic [DW-1:0] lb0_q [IMG_W];
    logic [DW-1:0] lb1_q [IMG_W];

    // Two previous columns per row; the incoming column completes the third tap.
    logic [DW-1:0] top_q [2];
    logic [DW-1:0] mid_q [2];
    logic [DW-1:0] bot_q [2];

    logic          accept;
    logic          lastPix;
    logic          interior;
    logic [CW-1:0] curX, curY;
    logic [AW-1:0] addr;
    logic [DW-1:0] topTap, midTap;

    always_comb begin
        accept   = bus.pix_valid && ((state_q == ACTIVE) || bus.sof);
        curX     = bus.sof ? '0 : col_q;
        curY     = bus.sof ? '0 : row_q;
        lastPix  = (curX == LAST_X) && (curY == LAST_Y);
        interior = (curX >= TWO) && (curY >= TWO);
        col_d    = (curX == LAST_X) ? '0 : curX + 1'b1;
        row_d    = lastPix ? '0 : ((curX == LAST_X) ? curY + 1'b1 : curY);
        addr     = curX[AW-1:0];
        topTap   = lb1_q[addr];
        midTap   = lb0_q[addr];
    end

    // Line buffers carry no reset: rows 0 and 1 of every frame refill them before any window.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[addr] <= lb0_q[addr];
            lb0_q[addr] <= bus.pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            col_q          <= '0;
            row_q          <= '0;
            top_q[0]       <= '0;
            top_q[1]       <= '0;
            mid_q[0]       <= '0;
            mid_q[1]       <= '0;
            bot_q[0]       <= '0;
            bot_q[1]       <= '0;
            bus.win_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.win_x      <= '0;
            bus.win_y      <= '0;
            bus.c1         <= '0;
            bus.c2         <= '0;
            bus.c3         <= '0;
            bus.c4         <= '0;
            bus.c5         <= '0;
            bus.c6         <= '0;
            bus.c7         <= '0;
            bus.c8         <= '0;
            bus.c9         <= '0;
        end else begin
            bus.win_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            if (accept) begin
                state_q  <= lastPix ? IDLE : ACTIVE;
                col_q    <= col_d;
                row_q    <= row_d;
                top_q[0] <= top_q[1];
                top_q[1] <= topTap;
                mid_q[0] <= mid_q[1];
                mid_q[1] <= midTap;
                bot_q[0] <= bot_q[1];
                bot_q[1] <= bus.pix_in;
                // A window is centred one column left and one row up of the newest pixel.
                if (interior) begin
                    bus.win_valid  <= 1'b1;
                    bus.frame_done <= lastPix;
                    bus.win_x      <= curX - 1'b1;
                    bus.win_y      <= curY - 1'b1;
                    bus.c1         <= top_q[0];
                    bus.c2         <= top_q[1];
                    bus.c3         <= topTap;
                    bus.c4         <= mid_q[0];
                    bus.c5         <= mid_q[1];
                    bus.c6         <= midTap;
                    bus.c7         <= bot_q[0];
                    bus.c8         <= bot_q[1];
                    bus.c9         <= bus.pix_in;
                end
            end
        end
    end
endmodule

// File: tb/tb_window_3x3_gen.sv
// Self-checking bench for window_3x3_gen on a 5x4 image: table-driven basic frame,
// hand-written corner sequences, and randomized traffic against an image-array model.
module tb_window_3x3_gen;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int DW = 8;
    localparam int CW = 11;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    window_3x3_gen_if #(.DW(DW), .CW(CW)) bus ();

    window_3x3_gen #(
        .IMG_W(W), .IMG_H(H), .DW(DW), .CW(CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int vectorCount = 0;
    int missCount   = 0;
    int winCount    = 0;
    int doneCount   = 0;

    logic [DW-1:0] img [H][W];
    bit            mActive;
    int            mX, mY;
    logic [DW-1:0] expC [9];
    logic          expValid, expDone;
    logic [CW-1:0] expX, expY;

    logic [DW-1:0] dutC [9];
    assign dutC[0] = bus.c1;
    assign dutC[1] = bus.c2;
    assign dutC[2] = bus.c3;
    assign dutC[3] = bus.c4;
    assign dutC[4] = bus.c5;
    assign dutC[5] = bus.c6;
    assign dutC[6] = bus.c7;
    assign dutC[7] = bus.c8;
    assign dutC[8] = bus.c9;

    typedef struct {
        logic          sof;
        logic [DW-1:0] pix;
        logic          eValid;
        int            eX;
        int            eY;
        logic [DW-1:0] eC1, eC5, eC9;
        logic          eDone;
    } vec_t;

    vec_t tbl [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectorCount++;
        if (act !== req) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic modelReset();
        mActive  = 1'b0;
        mX       = 0;
        mY       = 0;
        expValid = 1'b0;
        expDone  = 1'b0;
        expX     = '0;
        expY     = '0;
        for (int k = 0; k < 9; k++) expC[k] = '0;
    endtask

    // The model stores the frame as a 2D image and reads the window straight out of it.
    task automatic stepModel(input logic v, input logic s, input logic [DW-1:0] p);
        expValid = 1'b0;
        expDone  = 1'b0;
        if (v && (mActive || s)) begin
            if (s) begin
                mActive = 1'b1;
                mX      = 0;
                mY      = 0;
            end
            img[mY][mX] = p;
            if (mX >= 2 && mY >= 2) begin
                expValid = 1'b1;
                expDone  = (mX == W - 1) && (mY == H - 1);
                expX     = CW'(mX - 1);
                expY     = CW'(mY - 1);
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        expC[r * 3 + c] = img[mY - 2 + r][mX - 2 + c];
            end
            if (mX == W - 1) begin
                mX = 0;
                if (mY == H - 1) begin
                    mY      = 0;
                    mActive = 1'b0;
                end else begin
                    mY++;
                end
            end else begin
                mX++;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, " win_valid"}, 32'(bus.win_valid), 32'(expValid));
        check({tag, " frame_done"}, 32'(bus.frame_done), 32'(expDone));
        check({tag, " win_x"}, 32'(bus.win_x), 32'(expX));
        check({tag, " win_y"}, 32'(bus.win_y), 32'(expY));
        for (int k = 0; k < 9; k++)
            check($sformatf("%s c%0d", tag, k + 1), 32'(dutC[k]), 32'(expC[k]));
        if (bus.win_valid === 1'b1) winCount++;
        if (bus.frame_done === 1'b1) doneCount++;
    endtask

    task automatic applyStimulus(input logic v, input logic s, input logic [DW-1:0] p);
        bus.pix_valid = v;
        bus.sof       = s;
        bus.pix_in    = p;
        stepModel(v, s, p);
        @(posedge clk);
        #1;
        checkOutput("step");
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    endtask

    task automatic sendPixels(input int base, input int from, input int to);
        for (int i = from; i <= to; i++)
            applyStimulus(1'b1, 1'(i == 0), 8'(base + 10 * (i / W) + i % W));
    endtask

    task automatic checkWindow(input string tag, input logic [0:8][DW-1:0] e);
        for (int k = 0; k < 9; k++)
            check($sformatf("%s c%0d", tag, k + 1), 32'(dutC[k]), 32'(e[k]));
    endtask

    task automatic doReset();
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        rst_n         = 1'b0;
        #1;
        modelReset();
        checkOutput("reset async");
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset hold");
        rst_n = 1'b1;
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.pix_in    = '0;
        modelReset();

        for (int i = 0; i < 20; i++)
            tbl[i] = '{1'(i == 0), 8'(10 * (i / W) + i % W), 1'b0, 0, 0, 8'd0, 8'd0, 8'd0, 1'b0};
        tbl[12] = '{1'b0, 8'd22, 1'b1, 1, 1, 8'd0,  8'd11, 8'd22, 1'b0};
        tbl[13] = '{1'b0, 8'd23, 1'b1, 2, 1, 8'd1,  8'd12, 8'd23, 1'b0};
        tbl[14] = '{1'b0, 8'd24, 1'b1, 3, 1, 8'd2,  8'd13, 8'd24, 1'b0};
        tbl[17] = '{1'b0, 8'd32, 1'b1, 1, 2, 8'd10, 8'd21, 8'd32, 1'b0};
        tbl[18] = '{1'b0, 8'd33, 1'b1, 2, 2, 8'd11, 8'd22, 8'd33, 1'b0};
        tbl[19] = '{1'b0, 8'd34, 1'b1, 3, 2, 8'd12, 8'd23, 8'd34, 1'b1};

        #2;
        doReset();
        idleCycles(2);

        // Basic frame from the table, with the first window checked in full.
        winCount  = 0;
        doneCount = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, tbl[i].sof, tbl[i].pix);
            check("tbl win_valid", 32'(bus.win_valid), 32'(tbl[i].eValid));
            check("tbl frame_done", 32'(bus.frame_done), 32'(tbl[i].eDone));
            if (tbl[i].eValid) begin
                check("tbl win_x", 32'(bus.win_x), 32'(tbl[i].eX));
                check("tbl win_y", 32'(bus.win_y), 32'(tbl[i].eY));
                check("tbl c1", 32'(bus.c1), 32'(tbl[i].eC1));
                check("tbl c5", 32'(bus.c5), 32'(tbl[i].eC5));
                check("tbl c9", 32'(bus.c9), 32'(tbl[i].eC9));
            end
            if (i == 12)
                checkWindow("basic first", {8'd0, 8'd1, 8'd2, 8'd10, 8'd11, 8'd12, 8'd20, 8'd21, 8'd22});
        end
        checkWindow("basic last", {8'd12, 8'd13, 8'd14, 8'd22, 8'd23, 8'd24, 8'd32, 8'd33, 8'd34});
        idleCycles(3);
        check("basic windows", 32'(winCount), 32'd6);
        check("basic frame_done", 32'(doneCount), 32'd1);

        // Stalls after (3,1) and (4,2).
        winCount  = 0;
        doneCount = 0;
        sendPixels(0, 0, 8);
        idleCycles(3);
        sendPixels(0, 9, 14);
        idleCycles(2);
        sendPixels(0, 15, 19);
        checkWindow("stall last", {8'd12, 8'd13, 8'd14, 8'd22, 8'd23, 8'd24, 8'd32, 8'd33, 8'd34});
        idleCycles(2);
        check("stall windows", 32'(winCount), 32'd6);
        check("stall frame_done", 32'(doneCount), 32'd1);

        // Junk before sof must be ignored.
        winCount  = 0;
        doneCount = 0;
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 8'hFF);
        check("junk no windows", 32'(winCount), 32'd0);
        sendPixels(0, 0, 19);
        check("junk last frame_done", 32'(bus.frame_done), 32'd1);
        checkWindow("junk last", {8'd12, 8'd13, 8'd14, 8'd22, 8'd23, 8'd24, 8'd32, 8'd33, 8'd34});
        idleCycles(2);
        check("junk windows", 32'(winCount), 32'd6);

        // Reset after pixel (1,2), then a fresh frame offset by 100.
        sendPixels(0, 0, 11);
        doReset();
        winCount  = 0;
        doneCount = 0;
        sendPixels(100, 0, 12);
        checkWindow("post-reset first", {8'd100, 8'd101, 8'd102, 8'd110, 8'd111, 8'd112, 8'd120, 8'd121, 8'd122});
        sendPixels(100, 13, 19);
        idleCycles(2);
        check("post-reset windows", 32'(winCount), 32'd6);
        check("post-reset frame_done", 32'(doneCount), 32'd1);

        // sof where (3,1) would be restarts the frame.
        winCount  = 0;
        doneCount = 0;
        sendPixels(0, 0, 7);
        sendPixels(0, 0, 19);
        idleCycles(2);
        check("resync windows", 32'(winCount), 32'd6);
        check("resync frame_done", 32'(doneCount), 32'd1);

        // Randomized traffic: gaps, junk, resyncs and occasional resets.
        for (int n = 0; n < 1500; n++) begin
            logic v, s;
            if ($urandom_range(0, 299) == 0) begin
                doReset();
            end else begin
                v = 1'($urandom_range(0, 9) < 7);
                s = v && ((!mActive && $urandom_range(0, 3) == 0) || $urandom_range(0, 59) == 0);
                if (!v) s = 1'($urandom_range(0, 1));
                applyStimulus(v, s, 8'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
